// File: rtl/ring_rotator_pkg.sv
// ring_rotator_pkg: command encodings and FSM states shared by the ring rotator files
package ring_rotator_pkg;

    localparam logic [1:0] RING_OP_NOP  = 2'b00;
    localparam logic [1:0] RING_OP_ROTR = 2'b01;
    localparam logic [1:0] RING_OP_ROTL = 2'b10;
    localparam logic [1:0] RING_OP_LOAD = 2'b11;

    typedef enum logic {ST_IDLE, ST_ROT} state_t;

endpackage

// File: rtl/ring_rotator_rot_step.sv
// ring_rot_step: combinational rotate of a [0:W-1] ring by SH positions (dir 0 = toward higher index)
module ring_rot_step #(
    parameter int W  = 8,
    parameter int SH = 1
) (
    input  logic [0:W-1] d,
    input  logic         dir,
    output logic [0:W-1] y
);

    assign y = dir ? {d[SH:W-1], d[0:SH-1]} : {d[W-SH:W-1], d[0:W-SH-1]};

endmodule

// File: rtl/ring_rotator.sv
// ring_rotator: W-bit one-hot ring with load/rotate commands; RING_ROTATOR_BARREL_EN selects single-cycle rotation
module ring_rotator
    import ring_rotator_pkg::*;
#(
    parameter int             W         = 8,
    parameter logic [0:W-1]   RESET_VAL = {1'b1, {(W-1){1'b0}}},
    localparam int            AW        = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic [0:W-1]  cmd_data,
    output logic [0:W-1]  q,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] WL = AW'(0) + (AW+1)'(W);

    logic [AW:0]   amt_ext;
    logic [AW-1:0] amt_eff;
    logic          is_rot;
    logic          acc;

    assign amt_ext = {1'b0, cmd_amt};
    assign amt_eff = amt_ext >= WL ? AW'(amt_ext - WL) : cmd_amt;
    assign is_rot  = cmd_op == RING_OP_ROTR || cmd_op == RING_OP_ROTL;
    assign acc     = cmd_valid && cmd_ready;

`ifdef RING_ROTATOR_BARREL_EN

    logic [0:W-1] stg [AW+1];
    logic [0:W-1] sy  [AW];

    assign stg[0]    = q;
    assign busy      = 1'b0;
    assign cmd_ready = 1'b1;

    for (genvar k = 0; k < AW; k++) begin : g_stage
        ring_rot_step #(.W(W), .SH(1 << k)) u_step (
            .d   (stg[k]),
            .dir (cmd_op == RING_OP_ROTL),
            .y   (sy[k])
        );
        assign stg[k+1] = amt_eff[k] ? sy[k] : stg[k];
    end

    // every accepted command completes at its accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_VAL;
            done <= 1'b0;
        end else begin
            done <= acc;
            if (acc && cmd_op == RING_OP_LOAD) q <= cmd_data;
            else if (acc && is_rot) q <= stg[AW];
        end
    end

`else

    state_t        st, st_nx;
    logic [AW-1:0] rem;
    logic          dir;
    logic [0:W-1]  q_step;
    logic          start;

    assign start     = acc && is_rot && amt_eff != '0;
    assign busy      = st == ST_ROT;
    assign cmd_ready = ~busy;

    ring_rot_step #(.W(W), .SH(1)) u_step (
        .d   (q),
        .dir (dir),
        .y   (q_step)
    );

    // next state: a nonzero rotate enters ROT, the last step returns to IDLE
    always_comb begin
        st_nx = st;
        if (st == ST_IDLE && start) st_nx = ST_ROT;
        else if (st == ST_ROT && rem == AW'(1)) st_nx = ST_IDLE;
    end

    // ring contents, step counter and the completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= ST_IDLE;
            q    <= RESET_VAL;
            rem  <= '0;
            dir  <= 1'b0;
            done <= 1'b0;
        end else begin
            st   <= st_nx;
            done <= st == ST_ROT ? rem == AW'(1) : acc && !start;
            if (st == ST_ROT) begin
                q   <= q_step;
                rem <= rem - AW'(1);
            end else if (acc) begin
                if (cmd_op == RING_OP_LOAD) q <= cmd_data;
                if (start) begin
                    rem <= amt_eff;
                    dir <= cmd_op == RING_OP_ROTL;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_ring_rotator.sv
// tb_ring_rotator: directed checks of the iterative ring rotator at W=8
module tb_ring_rotator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_amt = 3'd0;
    logic [0:7] cmd_data = 8'b0;
    logic [0:7] q;
    logic       busy;
    logic       done;

    int checks = 0;
    int passed = 0;

    ring_rotator #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_r3 [3] = '{8'b01000000, 8'b00100000, 8'b00010000};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_q", 32'(q), 32'(8'b10000000));
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(cmd_ready), 1);

        send(2'b01, 3'd3, 8'h00);
        check("r3_busy", 32'(busy), 1);
        check("r3_ready", 32'(cmd_ready), 0);
        check("r3_q0", 32'(q), 32'(8'b10000000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("r3_step%0d", i + 1), 32'(q), 32'(exp_r3[i]));
            check($sformatf("r3_done%0d", i + 1), 32'(done), i == 2 ? 1 : 0);
        end
        check("r3_busy_end", 32'(busy), 0);
        @(negedge clk);
        check("r3_done_clear", 32'(done), 0);

        send(2'b11, 3'd0, 8'b11000001);
        check("load_q", 32'(q), 32'(8'b11000001));
        check("load_done", 32'(done), 1);
        check("load_busy", 32'(busy), 0);
        send(2'b10, 3'd1, 8'h00);
        check("l1_busy", 32'(busy), 1);
        @(negedge clk);
        check("l1_q", 32'(q), 32'(8'b10000011));
        check("l1_done", 32'(done), 1);
        send(2'b01, 3'd0, 8'h00);
        check("r0_done", 32'(done), 1);
        check("r0_q", 32'(q), 32'(8'b10000011));
        check("r0_busy", 32'(busy), 0);

        send(2'b01, 3'd5, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_q", 32'(q), 32'(8'b11100000));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_q", 32'(q), 32'(8'b10000000));
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        @(negedge clk);
        check("abort_done_after", 32'(done), 0);

        send(2'b11, 3'd0, 8'b10100000);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_amt   = 3'd3;
        @(negedge clk);
        cmd_op    = 2'b10;
        check("q2_busy", 32'(busy), 1);
        @(negedge clk);
        check("q2_hold1_done", 32'(done), 0);
        @(negedge clk);
        check("q2_hold2_ready", 32'(cmd_ready), 0);
        check("q2_hold2_q", 32'(q), 32'(8'b00101000));
        @(negedge clk);
        check("q2_first_done", 32'(done), 1);
        check("q2_first_q", 32'(q), 32'(8'b00010100));
        check("q2_first_busy", 32'(busy), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("q2_second_busy", 32'(busy), 1);
        check("q2_second_nodone", 32'(done), 0);
        @(negedge clk);
        @(negedge clk);
        check("q2_mid_done", 32'(done), 0);
        @(negedge clk);
        check("q2_restore_q", 32'(q), 32'(8'b10100000));
        check("q2_second_done", 32'(done), 1);
        @(negedge clk);
        check("q2_idle_busy", 32'(busy), 0);
        check("q2_idle_done", 32'(done), 0);

        send(2'b00, 3'd5, 8'hff);
        check("nop_done", 32'(done), 1);
        check("nop_q", 32'(q), 32'(8'b10100000));
        check("nop_busy", 32'(busy), 0);
        @(negedge clk);
        check("nop_done_clear", 32'(done), 0);
        check("idle_q_stable", 32'(q), 32'(8'b10100000));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
